// File: rtl/image_proc_pkg.sv
// Shared definitions for the image operation sequencer: opcodes, FSM states,
// command word layout and the dimension legality helper.
package image_proc_pkg;

    localparam int COORD_W = 11;
    localparam int PARAM_W = 8;
    localparam int OPC_W   = 2;
    localparam int CMD_W   = OPC_W + PARAM_W + 2 * COORD_W;

    typedef enum logic [OPC_W-1:0] {
        OP_BRIGHTNESS = 2'd0,
        OP_GRAYSCALE  = 2'd1,
        OP_ROTATE     = 2'd2,
        OP_ILLEGAL    = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        opcode_e              opcode;
        logic [PARAM_W-1:0]   param;
        logic [COORD_W-1:0]   width;
        logic [COORD_W-1:0]   height;
    } cmd_t;

    function automatic logic dim_legal(input logic [COORD_W-1:0] dim, input int max_dim);
        return (dim != '0) && (int'(dim) <= max_dim);
    endfunction

endpackage

// File: rtl/op_cmd_fifo.sv
// Synchronous command FIFO; full/empty come straight from the registered count.
module op_cmd_fifo
    import image_proc_pkg::*;
#(
    parameter int WIDTH = CMD_W,
    parameter int DEPTH = 2
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full queue can still take a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/image_op_sequencer.sv
// Pops queued image commands and walks the source frame in raster order,
// producing read/write pixel coordinates for the datapath.
//   state | meaning
//   IDLE  | waiting for a queued command
//   LOAD  | pop and latch command, reject illegal opcode / empty frame
//   SCAN  | issue one pixel beat per accepted handshake
//   DONE  | frame_done pulse, back to IDLE
module image_op_sequencer
    import image_proc_pkg::*;
#(
    parameter int MAX_DIM    = 2047,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OPC_W-1:0]   cmd_opcode,
    input  logic [PARAM_W-1:0] cmd_param,
    input  logic [COORD_W-1:0] img_width,
    input  logic [COORD_W-1:0] img_height,
    input  logic               pix_ready,
    output logic               pix_valid,
    output logic [COORD_W-1:0] rd_row,
    output logic [COORD_W-1:0] rd_col,
    output logic [COORD_W-1:0] wr_row,
    output logic [COORD_W-1:0] wr_col,
    output logic [OPC_W-1:0]   op_opcode,
    output logic [PARAM_W-1:0] op_param,
    output logic [COORD_W-1:0] out_width,
    output logic [COORD_W-1:0] out_height,
    output logic               frame_start,
    output logic               frame_done,
    output logic               busy,
    output logic               err_opcode
);

    seq_state_e         state_q, state_d;
    opcode_e            op_q, op_d;
    logic [PARAM_W-1:0] param_q, param_d;
    logic [COORD_W-1:0] w_q, w_d, h_q, h_d;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    cmd_t               cmd_in, head;
    logic [CMD_W-1:0]   fifo_rdata;
    logic               fifo_empty, fifo_full, rotate;

    assign cmd_in    = {cmd_opcode, cmd_param, img_width, img_height};
    assign head      = fifo_rdata;
    assign cmd_ready = !fifo_full;

    op_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (HCLK),
        .rst_n   (HRESETn),
        .push    (cmd_valid && cmd_ready),
        .wdata   (cmd_in),
        .pop     (state_q == ST_LOAD),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        param_d     = param_q;
        w_d         = w_q;
        h_d         = h_q;
        row_d       = row_q;
        col_d       = col_q;
        frame_start = 1'b0;
        err_opcode  = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD: begin
                row_d = '0;
                col_d = '0;
                // Illegal commands are dropped without disturbing the last frame's fields.
                if (head.opcode == OP_ILLEGAL) begin
                    err_opcode = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    op_d        = head.opcode;
                    param_d     = head.param;
                    w_d         = head.width;
                    h_d         = head.height;
                    frame_start = 1'b1;
                    state_d     = (dim_legal(head.width, MAX_DIM) && dim_legal(head.height, MAX_DIM))
                                  ? ST_SCAN : ST_DONE;
                end
            end
            ST_SCAN: begin
                if (pix_ready) begin
                    if (col_q == w_q - 11'd1) begin
                        col_d = '0;
                        if (row_q == h_q - 11'd1) begin
                            row_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            row_d = row_q + 11'd1;
                        end
                    end else begin
                        col_d = col_q + 11'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            op_q    <= OP_BRIGHTNESS;
            param_q <= '0;
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            param_q <= param_d;
            w_q     <= w_d;
            h_q     <= h_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign rotate     = (op_q == OP_ROTATE);
    assign pix_valid  = (state_q == ST_SCAN);
    assign frame_done = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign rd_row     = pix_valid ? row_q : '0;
    assign rd_col     = pix_valid ? col_q : '0;
    assign wr_row     = pix_valid ? (rotate ? col_q : row_q) : '0;
    assign wr_col     = pix_valid ? (rotate ? (h_q - 11'd1 - row_q) : col_q) : '0;
    assign op_opcode  = op_q;
    assign op_param   = param_q;
    assign out_width  = rotate ? h_q : w_q;
    assign out_height = rotate ? w_q : h_q;

endmodule

// File: tb/tb_image_op_sequencer.sv
// Directed bench for image_op_sequencer: raster scan, rotate mapping, stalls,
// queueing, illegal/empty commands and mid-frame reset.
module tb_image_op_sequencer;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode;
    logic [7:0]  cmd_param;
    logic [10:0] img_width, img_height;
    logic        pix_ready;
    logic        pix_valid;
    logic [10:0] rd_row, rd_col, wr_row, wr_col;
    logic [1:0]  op_opcode;
    logic [7:0]  op_param;
    logic [10:0] out_width, out_height;
    logic        frame_start, frame_done, busy, err_opcode;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    image_op_sequencer #(.MAX_DIM(2047), .FIFO_DEPTH(2)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_param   (cmd_param),
        .img_width   (img_width),
        .img_height  (img_height),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .op_opcode   (op_opcode),
        .op_param    (op_param),
        .out_width   (out_width),
        .out_height  (out_height),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_opcode  (err_opcode)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] prm,
                            input logic [10:0] w, input logic [10:0] h);
        int budget = 0;
        @(negedge HCLK);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_param  = prm;
        img_width  = w;
        img_height = h;
        while (!cmd_ready && budget < 200) begin
            @(negedge HCLK);
            budget++;
        end
        if (!cmd_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge HCLK);
        #1;
        cmd_valid  = 1'b0;
        img_width  = 11'h7FF;
        img_height = 11'h7FF;
    endtask

    // Follows one frame from frame_start to frame_done against a raster-order model.
    task automatic scan_frame(input logic [1:0] op, input logic [7:0] prm, input int w, input int h,
                              input bit toggle, output logic [21:0] first_wr, output logic [21:0] last_wr,
                              output int start_cyc, output int done_cyc);
        int budget = 0;
        int row = 0;
        int col = 0;
        int beats = 0;
        bit seen_done = 0;
        logic [10:0] er, ec;
        first_wr = '1;
        last_wr  = '1;
        start_cyc = 0;
        done_cyc  = 0;
        do begin
            @(negedge HCLK);
            budget++;
        end while (frame_start !== 1'b1 && budget < 300);
        if (frame_start !== 1'b1) begin
            check("start_timeout", 32'd0, 32'd1);
            return;
        end
        start_cyc = cyc;
        budget = 0;
        while (budget < 300) begin
            @(negedge HCLK);
            budget++;
            if (toggle) pix_ready = ~pix_ready;
            if (frame_done === 1'b1) begin
                seen_done = 1;
                done_cyc = cyc;
                break;
            end
            check("pv_in_scan", pix_valid, 1'b1);
            check("busy_scan", busy, 1'b1);
            er = (op == 2'd2) ? 11'(col) : 11'(row);
            ec = (op == 2'd2) ? 11'(h - 1 - row) : 11'(col);
            check("rd_row", rd_row, row);
            check("rd_col", rd_col, col);
            check("wr_row", wr_row, er);
            check("wr_col", wr_col, ec);
            check("op_opcode", op_opcode, op);
            check("op_param", op_param, prm);
            if (pix_valid && pix_ready) begin
                if (beats == 0) first_wr = {wr_row, wr_col};
                last_wr = {wr_row, wr_col};
                beats++;
                if (col == w - 1) begin
                    col = 0;
                    row++;
                end else begin
                    col++;
                end
            end
        end
        pix_ready = 1'b1;
        check("done_seen", seen_done, 1'b1);
        check("beat_count", beats, w * h);
        check("pv_at_done", pix_valid, 1'b0);
        if (!toggle) check("start_to_done", done_cyc - start_cyc, w * h + 1);
    endtask

    logic [21:0] fw, lw;
    int s0, d0, s1, d1, s2, d2;
    int n_err, n_start, n_done, n_pv;

    initial begin
        HRESETn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 2'd0;
        cmd_param  = 8'd0;
        img_width  = 11'd0;
        img_height = 11'd0;
        pix_ready  = 1'b1;
        #23;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err", err_opcode, 1'b0);
        check("rst_out_dims", {out_width, out_height}, 22'd0);
        check("rst_op", {op_opcode, op_param}, 10'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // GRAYSCALE 4x3, ready high
        send_cmd(2'd1, 8'h55, 11'd4, 11'd3);
        scan_frame(2'd1, 8'h55, 4, 3, 1'b0, fw, lw, s0, d0);
        check("gray_first_wr", fw, {11'd0, 11'd0});
        check("gray_last_wr", lw, {11'd2, 11'd3});
        check("gray_out_dims", {out_width, out_height}, {11'd4, 11'd3});

        // ROTATE 4x3
        send_cmd(2'd2, 8'h00, 11'd4, 11'd3);
        scan_frame(2'd2, 8'h00, 4, 3, 1'b0, fw, lw, s0, d0);
        check("rot_first_wr", fw, {11'd0, 11'd2});
        check("rot_last_wr", lw, {11'd3, 11'd0});
        repeat (3) @(negedge HCLK);
        check("rot_out_w_hold", out_width, 11'd3);
        check("rot_out_h_hold", out_height, 11'd4);
        check("idle_busy", busy, 1'b0);

        // BRIGHTNESS 2x2 with stalls
        send_cmd(2'd0, 8'hF0, 11'd2, 11'd2);
        scan_frame(2'd0, 8'hF0, 2, 2, 1'b1, fw, lw, s0, d0);
        check("bri_last_wr", lw, {11'd1, 11'd1});
        check("bri_param", op_param, 8'hF0);

        // Three commands queued behind a scanning frame
        @(negedge HCLK);
        fork
            begin
                send_cmd(2'd1, 8'h00, 11'd4, 11'd3);
                send_cmd(2'd0, 8'h11, 11'd2, 11'd1);
                send_cmd(2'd2, 8'h22, 11'd1, 11'd2);
                @(negedge HCLK);
                check("queue_full_ready", cmd_ready, 1'b0);
                check("queue_full_busy", busy, 1'b1);
            end
            scan_frame(2'd1, 8'h00, 4, 3, 1'b0, fw, lw, s0, d0);
        join
        scan_frame(2'd0, 8'h11, 2, 1, 1'b0, fw, lw, s1, d1);
        scan_frame(2'd2, 8'h22, 1, 2, 1'b0, fw, lw, s2, d2);
        check("gap_a_b", s1 - d0, 2);
        check("gap_b_c", s2 - d1, 2);
        check("rot12_first_wr", fw, {11'd0, 11'd1});
        check("rot12_dims", {out_width, out_height}, {11'd2, 11'd1});

        // Illegal opcode then zero-width GRAYSCALE
        n_err = 0; n_start = 0; n_done = 0; n_pv = 0;
        @(negedge HCLK);
        fork
            begin
                send_cmd(2'd3, 8'h77, 11'd4, 11'd3);
                send_cmd(2'd1, 8'h00, 11'd0, 11'd3);
            end
            repeat (20) begin
                @(negedge HCLK);
                n_err   += int'(err_opcode);
                n_start += int'(frame_start);
                n_done  += int'(frame_done);
                n_pv    += int'(pix_valid);
            end
        join
        check("ill_err_pulses", n_err, 1);
        check("zero_starts", n_start, 1);
        check("zero_dones", n_done, 1);
        check("zero_beats", n_pv, 0);
        check("zero_op", op_opcode, 2'd1);
        check("zero_dims", {out_width, out_height}, {11'd0, 11'd3});

        // Reset in the middle of a 4x3 frame
        send_cmd(2'd1, 8'h00, 11'd4, 11'd3);
        n_start = 0;
        while (frame_start !== 1'b1 && n_start < 100) begin
            @(negedge HCLK);
            n_start++;
        end
        check("rst_test_start", frame_start, 1'b1);
        repeat (6) @(negedge HCLK);
        check("pre_rst_row", rd_row, 11'd1);
        check("pre_rst_col", rd_col, 11'd1);
        HRESETn = 1'b0;
        #1;
        check("mid_rst_pv", pix_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b1);
        check("mid_rst_coords", {rd_row, rd_col, wr_row, wr_col}, 44'd0);
        check("mid_rst_fields", {op_opcode, op_param, out_width, out_height}, 32'd0);
        n_done = 0;
        repeat (3) begin
            @(negedge HCLK);
            n_done += int'(frame_done);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        n_done += int'(frame_done);
        check("mid_rst_no_done", n_done, 0);
        send_cmd(2'd1, 8'h00, 11'd4, 11'd3);
        scan_frame(2'd1, 8'h00, 4, 3, 1'b0, fw, lw, s0, d0);
        check("post_rst_first_wr", fw, {11'd0, 11'd0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
